// File: rtl/mem_arbiter.sv
// Two-port to one-port memory arbiter: merges instruction refill and data ports
// onto one shared REQ/VALID memory port, round-robin or fixed data priority.
module mem_arbiter #(
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic        clk,
    input  logic        res,
    input  logic        instr_req,
    input  logic [31:0] instr_adr,
    output logic        instr_valid,
    output logic [31:0] instr_read,
    input  logic        data_req,
    input  logic        data_we,
    input  logic [3:0]  data_be,
    input  logic [31:0] data_adr,
    input  logic [31:0] data_wdata,
    output logic        data_valid,
    output logic [31:0] data_read,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_adr,
    output logic [31:0] mem_wdata,
    input  logic        mem_valid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D
    } state_t;

    typedef enum logic {
        PORT_I,
        PORT_D
    } port_t;

    state_t state;
    port_t  last;
    logic   start_i;
    logic   start_d;

    assign instr_read  = mem_rdata;
    assign data_read   = mem_rdata;
    // Valids are gated by res so nothing completes in the reset cycle.
    assign instr_valid = !res && mem_valid && (state == BUSY_I);
    assign data_valid  = !res && mem_valid && (state == BUSY_D);

    // A grant happens from IDLE, or as a direct hand-over to the other port on completion;
    // the completing port's own req is stale in that cycle and is not looked at.
    always_comb begin
        start_i = 1'b0;
        start_d = 1'b0;
        case (state)
            IDLE: begin
                if (instr_req && data_req) begin
                    if (FIXED_PRIO != 0 || last == PORT_I) begin
                        start_d = 1'b1;
                    end else begin
                        start_i = 1'b1;
                    end
                end else begin
                    start_i = instr_req;
                    start_d = data_req;
                end
            end
            BUSY_I:  start_d = mem_valid && data_req;
            BUSY_D:  start_i = mem_valid && instr_req;
            default: begin
                start_i = 1'b0;
                start_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state     <= IDLE;
            last      <= PORT_D;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_adr   <= '0;
            mem_wdata <= '0;
        end else if (start_i) begin
            state     <= BUSY_I;
            last      <= PORT_I;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_be    <= '1;
            mem_adr   <= instr_adr;
            mem_wdata <= '0;
        end else if (start_d) begin
            state     <= BUSY_D;
            last      <= PORT_D;
            mem_req   <= 1'b1;
            mem_we    <= data_we;
            mem_be    <= data_be;
            mem_adr   <= data_adr;
            mem_wdata <= data_wdata;
        end else if (state != IDLE && mem_valid) begin
            state   <= IDLE;
            mem_req <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;

    logic        clk;
    logic        res;
    logic        instr_req;
    logic [31:0] instr_adr;
    logic        data_req;
    logic        data_we;
    logic [3:0]  data_be;
    logic [31:0] data_adr;
    logic [31:0] data_wdata;
    logic        mem_valid;
    logic [31:0] mem_rdata;

    logic        rr_instr_valid, rr_data_valid, rr_mem_req, rr_mem_we;
    logic [31:0] rr_instr_read, rr_data_read, rr_mem_adr, rr_mem_wdata;
    logic [3:0]  rr_mem_be;
    logic        fp_instr_valid, fp_data_valid, fp_mem_req, fp_mem_we;
    logic [31:0] fp_instr_read, fp_data_read, fp_mem_adr, fp_mem_wdata;
    logic [3:0]  fp_mem_be;

    logic        sel_fp;
    logic        o_instr_valid, o_data_valid, o_mem_req, o_mem_we;
    logic [31:0] o_instr_read, o_data_read, o_mem_adr, o_mem_wdata;
    logic [3:0]  o_mem_be;

    int pass_n = 0;
    int chk_n  = 0;

    bit          mem_auto;
    bit          in_txn;
    int unsigned cnt;
    int unsigned lat_min = 0;
    int unsigned lat_max = 0;
    logic [31:0] rd_value;

    int          cap_which, cap_cyc;
    logic        cap_we;
    logic [3:0]  cap_be;
    logic [31:0] cap_adr, cap_wdata, cap_read, cap_rdata;

    mem_arbiter #(.FIXED_PRIO(0)) dut (
        .clk(clk), .res(res),
        .instr_req(instr_req), .instr_adr(instr_adr),
        .instr_valid(rr_instr_valid), .instr_read(rr_instr_read),
        .data_req(data_req), .data_we(data_we), .data_be(data_be),
        .data_adr(data_adr), .data_wdata(data_wdata),
        .data_valid(rr_data_valid), .data_read(rr_data_read),
        .mem_req(rr_mem_req), .mem_we(rr_mem_we), .mem_be(rr_mem_be),
        .mem_adr(rr_mem_adr), .mem_wdata(rr_mem_wdata),
        .mem_valid(mem_valid), .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.FIXED_PRIO(1)) dut_fp (
        .clk(clk), .res(res),
        .instr_req(instr_req), .instr_adr(instr_adr),
        .instr_valid(fp_instr_valid), .instr_read(fp_instr_read),
        .data_req(data_req), .data_we(data_we), .data_be(data_be),
        .data_adr(data_adr), .data_wdata(data_wdata),
        .data_valid(fp_data_valid), .data_read(fp_data_read),
        .mem_req(fp_mem_req), .mem_we(fp_mem_we), .mem_be(fp_mem_be),
        .mem_adr(fp_mem_adr), .mem_wdata(fp_mem_wdata),
        .mem_valid(mem_valid), .mem_rdata(mem_rdata)
    );

    assign o_instr_valid = sel_fp ? fp_instr_valid : rr_instr_valid;
    assign o_data_valid  = sel_fp ? fp_data_valid  : rr_data_valid;
    assign o_instr_read  = sel_fp ? fp_instr_read  : rr_instr_read;
    assign o_data_read   = sel_fp ? fp_data_read   : rr_data_read;
    assign o_mem_req     = sel_fp ? fp_mem_req     : rr_mem_req;
    assign o_mem_we      = sel_fp ? fp_mem_we      : rr_mem_we;
    assign o_mem_be      = sel_fp ? fp_mem_be      : rr_mem_be;
    assign o_mem_adr     = sel_fp ? fp_mem_adr     : rr_mem_adr;
    assign o_mem_wdata   = sel_fp ? fp_mem_wdata   : rr_mem_wdata;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: answers each new mem_req after a random latency, sharing the reset.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (mem_auto) begin
                if (res) begin
                    in_txn    = 1'b0;
                    mem_valid = 1'b0;
                end else begin
                    if (mem_valid) in_txn = 1'b0;
                    mem_valid = 1'b0;
                    mem_rdata = $urandom;
                    if (!in_txn && o_mem_req === 1'b1) begin
                        in_txn = 1'b1;
                        cnt    = $urandom_range(lat_max, lat_min);
                    end
                    if (in_txn) begin
                        if (cnt == 0) begin
                            mem_valid = 1'b1;
                            mem_rdata = rd_value;
                        end else begin
                            cnt--;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by time limit, want finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        res       = 1'b1;
        instr_req = 1'b0;
        data_req  = 1'b0;
        mem_auto  = 1'b1;
        mem_valid = 1'b0;
        @(posedge clk);
        #1;
        res    = 1'b0;
        in_txn = 1'b0;
    endtask

    // Waits (bounded) for a requester valid; returns at posedge+1 of the following cycle.
    task automatic wait_valid(input int budget);
        cap_which = -1;
        cap_cyc   = -1;
        for (int c = 0; c < budget && cap_which < 0; c++) begin
            @(negedge clk);
            if (o_instr_valid === 1'b1 || o_data_valid === 1'b1) begin
                cap_cyc   = c;
                cap_which = (o_instr_valid === 1'b1 && o_data_valid === 1'b1) ? 2 :
                            (o_instr_valid === 1'b1) ? 0 : 1;
                cap_adr   = o_mem_adr;
                cap_we    = o_mem_we;
                cap_be    = o_mem_be;
                cap_wdata = o_mem_wdata;
                cap_read  = (o_instr_valid === 1'b1) ? o_instr_read : o_data_read;
                cap_rdata = mem_rdata;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        mem_auto = 1'b0;
        for (int i = 0; i < 2; i++) begin
            res        = 1'b1;
            instr_req  = 1'b1;
            instr_adr  = $urandom;
            data_req   = 1'($urandom);
            data_we    = 1'($urandom);
            data_be    = 4'($urandom);
            data_adr   = $urandom;
            data_wdata = $urandom;
            mem_valid  = 1'b1;
            mem_rdata  = $urandom;
            if (i == 0) begin
                @(posedge clk);
                #1;
            end
        end
        @(negedge clk);
        chk_n++; if ({o_mem_req, o_mem_we, o_mem_be, o_mem_adr, o_mem_wdata} !== 70'd0)
            $display("FAIL reset_mem: got req=%b we=%b be=%h adr=%h wd=%h want all 0",
                     o_mem_req, o_mem_we, o_mem_be, o_mem_adr, o_mem_wdata);
        else pass_n++;
        chk_n++; if ({o_instr_valid, o_data_valid} !== 2'b00)
            $display("FAIL reset_valid: got %b%b want 00", o_instr_valid, o_data_valid);
        else pass_n++;
        @(posedge clk);
        #1;
        res       = 1'b0;
        mem_valid = 1'b0;
        instr_req = 1'b1;
        instr_adr = 32'h0000_ABC0;
        data_req  = 1'b0;
        @(negedge clk);
        chk_n++; if (o_mem_req !== 1'b0) $display("FAIL reset_no_early_grant: got %b want 0", o_mem_req);
        else pass_n++;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk_n++; if ({o_mem_req, o_mem_adr, o_mem_be} !== {1'b1, 32'h0000_ABC0, 4'hF})
            $display("FAIL reset_first_grant: got req=%b adr=%h be=%h want 1 0000abc0 f",
                     o_mem_req, o_mem_adr, o_mem_be);
        else pass_n++;
    endtask

    task automatic test_single_read();
        do_reset();
        lat_min   = 3;
        lat_max   = 3;
        rd_value  = 32'hDEAD_BEEF;
        instr_req = 1'b1;
        instr_adr = 32'h100;
        @(negedge clk);
        chk_n++; if (o_mem_req !== 1'b0) $display("FAIL single_no_comb: got %b want 0", o_mem_req);
        else pass_n++;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk_n++; if ({o_mem_req, o_mem_we, o_mem_be, o_mem_adr, o_mem_wdata} !== {1'b1, 1'b0, 4'hF, 32'h100, 32'h0})
            $display("FAIL single_grant: got req=%b we=%b be=%h adr=%h wd=%h want 1 0 f 100 0",
                     o_mem_req, o_mem_we, o_mem_be, o_mem_adr, o_mem_wdata);
        else pass_n++;
        @(posedge clk);
        #1;
        wait_valid(10);
        chk_n++; if (cap_which !== 0 || cap_cyc !== 2)
            $display("FAIL single_valid: got port=%0d cyc=%0d want port=0 cyc=2", cap_which, cap_cyc);
        else pass_n++;
        chk_n++; if (cap_read !== 32'hDEAD_BEEF)
            $display("FAIL single_read: got %h want deadbeef", cap_read);
        else pass_n++;
        instr_req = 1'b0;
        @(negedge clk);
        chk_n++; if ({o_instr_valid, o_data_valid, o_mem_req} !== 3'b000)
            $display("FAIL single_pulse: got iv=%b dv=%b req=%b want 000", o_instr_valid, o_data_valid, o_mem_req);
        else pass_n++;
    endtask

    task automatic test_simultaneous();
        int ni;
        int nd;
        int exp_port;
        do_reset();
        lat_min    = 0;
        lat_max    = 0;
        ni         = 0;
        nd         = 0;
        instr_req  = 1'b1;
        instr_adr  = 32'h200;
        data_req   = 1'b1;
        data_we    = 1'b1;
        data_be    = 4'b0011;
        data_adr   = 32'h8000_0000;
        data_wdata = 32'h1234;
        for (int k = 0; k < 8; k++) begin
            rd_value = $urandom;
            wait_valid(10);
            exp_port = k % 2;
            chk_n++; if (cap_which !== exp_port || cap_cyc !== ((k == 0) ? 1 : 0))
                $display("FAIL simul_order[%0d]: got port=%0d cyc=%0d want port=%0d cyc=%0d",
                         k, cap_which, cap_cyc, exp_port, (k == 0) ? 1 : 0);
            else pass_n++;
            chk_n++; if (cap_read !== rd_value)
                $display("FAIL simul_read[%0d]: got %h want %h", k, cap_read, rd_value);
            else pass_n++;
            if (exp_port == 0) begin
                chk_n++; if ({cap_adr, cap_we, cap_be, cap_wdata} !== {instr_adr, 1'b0, 4'hF, 32'h0})
                    $display("FAIL simul_ipay[%0d]: got adr=%h we=%b be=%h wd=%h want adr=%h 0 f 0",
                             k, cap_adr, cap_we, cap_be, cap_wdata, instr_adr);
                else pass_n++;
            end else begin
                chk_n++; if ({cap_adr, cap_we, cap_be, cap_wdata} !== {data_adr, data_we, data_be, data_wdata})
                    $display("FAIL simul_dpay[%0d]: got adr=%h we=%b be=%h wd=%h want adr=%h we=%b be=%h wd=%h",
                             k, cap_adr, cap_we, cap_be, cap_wdata, data_adr, data_we, data_be, data_wdata);
                else pass_n++;
            end
            if (cap_which == 0) begin
                ni++;
                if (ni < 4) instr_adr = 32'h200 + 32'(4 * ni);
                else instr_req = 1'b0;
            end else if (cap_which == 1) begin
                nd++;
                if (nd < 4) begin
                    data_adr   = data_adr + 32'd4;
                    data_we    = 1'($urandom);
                    data_be    = 4'($urandom);
                    data_wdata = $urandom;
                end else begin
                    data_req = 1'b0;
                end
            end
        end
    endtask

    task automatic test_fixed_prio();
        sel_fp = 1'b1;
        do_reset();
        lat_min = 0;
        lat_max = 2;
        for (int r = 0; r < 4; r++) begin
            data_req   = 1'b1;
            data_we    = 1'($urandom);
            data_be    = 4'($urandom);
            data_adr   = $urandom;
            data_wdata = $urandom;
            rd_value   = $urandom;
            wait_valid(10);
            chk_n++; if (cap_which !== 1) $display("FAIL fp_lone[%0d]: got port=%0d want 1", r, cap_which);
            else pass_n++;
            // last grant is now D; round-robin would hand the tie to instruction
            instr_req  = 1'b1;
            instr_adr  = $urandom;
            data_adr   = $urandom;
            data_wdata = $urandom;
            wait_valid(10);
            chk_n++; if (cap_which !== 1 || cap_adr !== data_adr)
                $display("FAIL fp_tie[%0d]: got port=%0d adr=%h want port=1 adr=%h", r, cap_which, cap_adr, data_adr);
            else pass_n++;
            data_req = 1'b0;
            wait_valid(10);
            chk_n++; if (cap_which !== 0 || cap_adr !== instr_adr)
                $display("FAIL fp_instr[%0d]: got port=%0d adr=%h want port=0 adr=%h", r, cap_which, cap_adr, instr_adr);
            else pass_n++;
            instr_req = 1'b0;
        end
        sel_fp = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        mem_auto   = 1'b0;
        mem_valid  = 1'b0;
        instr_req  = 1'b0;
        data_req   = 1'b1;
        data_we    = 1'b1;
        data_be    = 4'hF;
        data_adr   = 32'h40;
        data_wdata = $urandom;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk_n++; if (o_mem_req !== 1'b1 || o_mem_adr !== 32'h40)
            $display("FAIL rmid_busy: got req=%b adr=%h want 1 00000040", o_mem_req, o_mem_adr);
        else pass_n++;
        @(posedge clk);
        #1;
        res       = 1'b1;
        mem_valid = 1'b1;
        mem_rdata = $urandom;
        @(negedge clk);
        chk_n++; if (o_data_valid !== 1'b0) $display("FAIL rmid_valid_in_reset: got %b want 0", o_data_valid);
        else pass_n++;
        @(posedge clk);
        #1;
        res      = 1'b0;
        data_req = 1'b0;
        @(negedge clk);
        chk_n++; if ({o_mem_req, o_instr_valid, o_data_valid} !== 3'b000)
            $display("FAIL rmid_after: got req=%b iv=%b dv=%b want 000", o_mem_req, o_instr_valid, o_data_valid);
        else pass_n++;
        @(posedge clk);
        #1;
        mem_valid = 1'b0;
        instr_req = 1'b1;
        instr_adr = 32'h300;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk_n++; if (o_mem_req !== 1'b1 || o_mem_adr !== 32'h300)
            $display("FAIL rmid_idle: got req=%b adr=%h want 1 00000300", o_mem_req, o_mem_adr);
        else pass_n++;
        @(posedge clk);
        #1;
        mem_auto = 1'b1;
        in_txn   = 1'b0;
        lat_min  = 0;
        lat_max  = 0;
        rd_value = $urandom;
        wait_valid(10);
        chk_n++; if (cap_which !== 0 || cap_read !== rd_value)
            $display("FAIL rmid_resume: got port=%0d read=%h want 0 %h", cap_which, cap_read, rd_value);
        else pass_n++;
        instr_req = 1'b0;
    endtask

    task automatic test_stray();
        do_reset();
        mem_auto  = 1'b0;
        mem_valid = 1'b1;
        mem_rdata = $urandom;
        @(negedge clk);
        chk_n++; if ({o_instr_valid, o_data_valid, o_mem_req} !== 3'b000)
            $display("FAIL stray_valid: got iv=%b dv=%b req=%b want 000", o_instr_valid, o_data_valid, o_mem_req);
        else pass_n++;
        chk_n++; if (o_instr_read !== mem_rdata || o_data_read !== mem_rdata)
            $display("FAIL stray_read_follow: got %h/%h want %h", o_instr_read, o_data_read, mem_rdata);
        else pass_n++;
        @(posedge clk);
        #1;
        mem_valid = 1'b0;
        mem_auto  = 1'b1;
        in_txn    = 1'b0;
        lat_min   = 1;
        lat_max   = 1;
        rd_value  = $urandom;
        data_req  = 1'b1;
        data_we   = 1'b0;
        data_be   = 4'hF;
        data_adr  = $urandom;
        wait_valid(10);
        chk_n++; if (cap_which !== 1 || cap_cyc !== 2 || cap_read !== rd_value || cap_adr !== data_adr)
            $display("FAIL stray_next: got port=%0d cyc=%0d read=%h adr=%h want 1 2 %h %h",
                     cap_which, cap_cyc, cap_read, cap_adr, rd_value, data_adr);
        else pass_n++;
        data_req = 1'b0;
    endtask

    // Transaction-level reference: who owns the shared port, what it must carry, and who gets the next grant.
    task automatic test_random();
        int          own;
        int          last_p;
        int          nxt;
        bit          want_i, want_d, ev_i, ev_d, done_i, done_d;
        logic        p_we;
        logic [3:0]  p_be;
        logic [31:0] p_adr, p_wdata;
        do_reset();
        lat_min = 0;
        lat_max = 3;
        own     = -1;
        last_p  = 1;
        done_i  = 1'b0;
        done_d  = 1'b0;
        p_we    = 1'b0;
        p_be    = '0;
        p_adr   = '0;
        p_wdata = '0;
        for (int c = 0; c < 400; c++) begin
            rd_value = $urandom;
            if (done_i || !instr_req) begin
                instr_req = 1'($urandom);
                instr_adr = $urandom;
            end
            if (done_d || !data_req) begin
                data_req   = 1'($urandom);
                data_we    = 1'($urandom);
                data_be    = 4'($urandom);
                data_adr   = $urandom;
                data_wdata = $urandom;
            end
            @(negedge clk);
            ev_i = (own == 0) && mem_valid;
            ev_d = (own == 1) && mem_valid;
            chk_n++; if (o_instr_valid !== ev_i || o_data_valid !== ev_d)
                $display("FAIL rand_valid[%0d]: got iv=%b dv=%b want iv=%b dv=%b", c, o_instr_valid, o_data_valid, ev_i, ev_d);
            else pass_n++;
            chk_n++; if (o_mem_req !== (own >= 0))
                $display("FAIL rand_req[%0d]: got %b want %b", c, o_mem_req, own >= 0);
            else pass_n++;
            if (own >= 0) begin
                chk_n++; if ({o_mem_we, o_mem_be, o_mem_adr, o_mem_wdata} !== {p_we, p_be, p_adr, p_wdata})
                    $display("FAIL rand_payload[%0d]: got we=%b be=%h adr=%h wd=%h want we=%b be=%h adr=%h wd=%h",
                             c, o_mem_we, o_mem_be, o_mem_adr, o_mem_wdata, p_we, p_be, p_adr, p_wdata);
                else pass_n++;
            end
            chk_n++; if (o_instr_read !== mem_rdata || o_data_read !== mem_rdata)
                $display("FAIL rand_read[%0d]: got %h/%h want %h", c, o_instr_read, o_data_read, mem_rdata);
            else pass_n++;
            if (own < 0 || mem_valid) begin
                want_i = instr_req && (own != 0);
                want_d = data_req && (own != 1);
                if (want_i && want_d) nxt = 1 - last_p;
                else if (want_i) nxt = 0;
                else if (want_d) nxt = 1;
                else nxt = -1;
                own = nxt;
                if (nxt == 0) begin
                    {p_we, p_be, p_adr, p_wdata} = {1'b0, 4'hF, instr_adr, 32'h0};
                    last_p = 0;
                end else if (nxt == 1) begin
                    {p_we, p_be, p_adr, p_wdata} = {data_we, data_be, data_adr, data_wdata};
                    last_p = 1;
                end
            end
            done_i = ev_i;
            done_d = ev_d;
            @(posedge clk);
            #1;
        end
        instr_req = 1'b0;
        data_req  = 1'b0;
    endtask

    initial begin
        res        = 1'b1;
        instr_req  = 1'b0;
        instr_adr  = '0;
        data_req   = 1'b0;
        data_we    = 1'b0;
        data_be    = '0;
        data_adr   = '0;
        data_wdata = '0;
        mem_valid  = 1'b0;
        mem_rdata  = '0;
        rd_value   = '0;
        sel_fp     = 1'b0;
        mem_auto   = 1'b0;
        in_txn     = 1'b0;
        test_reset();
        test_single_read();
        test_simultaneous();
        test_fixed_prio();
        test_reset_mid();
        test_stray();
        test_random();
        $display("%0d/%0d checks passed", pass_n, chk_n);
        $finish;
    end

endmodule
